// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
package tt_sweep_pkg;

  localparam int N_IN_MAX = 6;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // Number of truth-table rows for n inputs; clamped so a bad N_IN cannot explode widths.
  function automatic int rows(input int n);
    return 1 << ((n > N_IN_MAX) ? N_IN_MAX : n);
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-delay down-counter: loaded when a vector is applied, expires on its last wait cycle.
module tt_settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count_en,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count_en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // Terminal count of 1 makes a load of S produce exactly S counting cycles.
  assign expired = count_en && (count == W'(1));

endmodule

// File: rtl/tt_sweep_checker.sv
// Drives every input vector into a circuit, samples its output after a settle delay
// and compares the captured truth table against an expected one.
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter  int N_IN     = 3,
  parameter  int SETTLE_W = 8,
  localparam int ROWS     = rows(N_IN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [ROWS-1:0]     expected_tt,
  output logic [N_IN-1:0]     dut_in,
  input  logic                dut_out,
  output logic                busy,
  output logic                done,
  output logic [ROWS-1:0]     observed_tt,
  output logic [N_IN:0]       mismatch_count,
  output logic                match
);

  state_t              state, state_nxt;
  logic [N_IN-1:0]     idx;
  logic [ROWS-1:0]     exp_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                settle_expired;
  logic                last_row;
  logic                accept;
  logic                capture;

  assign last_row = &idx;
  assign accept   = (state == IDLE) && start;
  // Abort takes priority over sampling, including the final row.
  assign capture  = (state == SAMPLE) && !abort;

  tt_settle_timer #(
    .W(SETTLE_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == APPLY),
    .load_val (settle_q),
    .count_en (state == SETTLE),
    .expired  (settle_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    dut_in    = '0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = APPLY;
      end
      APPLY: begin
        busy   = 1'b1;
        dut_in = idx;
        if (abort)                 state_nxt = IDLE;
        else if (settle_q != '0)   state_nxt = SETTLE;
        else                       state_nxt = SAMPLE;
      end
      SETTLE: begin
        busy   = 1'b1;
        dut_in = idx;
        if (abort)               state_nxt = IDLE;
        else if (settle_expired) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy   = 1'b1;
        dut_in = idx;
        if (abort)         state_nxt = IDLE;
        else if (last_row) state_nxt = DONE;
        else               state_nxt = APPLY;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx            <= '0;
      exp_q          <= '0;
      settle_q       <= '0;
      observed_tt    <= '0;
      mismatch_count <= '0;
      match          <= 1'b0;
    end else begin
      if (accept) begin
        idx            <= '0;
        exp_q          <= expected_tt;
        settle_q       <= settle_cycles;
        observed_tt    <= '0;
        mismatch_count <= '0;
        match          <= 1'b0;
      end else if (busy && abort) begin
        idx   <= '0;
        match <= 1'b0;
      end else if (capture) begin
        observed_tt[idx] <= dut_out;
        if (dut_out != exp_q[idx]) mismatch_count <= mismatch_count + (N_IN+1)'(1);
        if (!last_row) idx <= idx + N_IN'(1);
      end else if (state == DONE) begin
        idx   <= '0;
        match <= (mismatch_count == '0);
      end
    end
  end

endmodule
